// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and data_memory, with youngest-match load forwarding.
// Optional feature macro: STORE_BUFFER_COALESCE_EN (merge a store into the youngest entry on address match).
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_req,
    input  logic [AW-1:0]              ld_addr,
    output logic [DW-1:0]              ld_data,
    output logic                       ld_hit,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic                       mem_write,
    output logic                       mem_read,
    input  logic [DW-1:0]              mem_rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {PORT_IDLE, PORT_LOAD, PORT_DRAIN} port_e;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    port_e            w_sel;
    logic             w_push;
    logic             w_merge;
    logic             w_alloc;
    logic             w_drain;
    logic             w_hit;
    logic [DW-1:0]    w_fwd;
    logic [PW-1:0]    w_youngest;

    assign st_ready   = (r_count < CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign w_push     = st_valid && st_ready;
    assign w_youngest = r_tail - PW'(1);
    assign w_drain    = (w_sel == PORT_DRAIN);

`ifdef STORE_BUFFER_COALESCE_EN
    // A head entry leaving this cycle cannot absorb the new data, so it allocates instead.
    assign w_merge = w_push && r_valid[w_youngest] && (r_addr[w_youngest] == st_addr)
                     && !(w_drain && (w_youngest == r_head));
`else
    assign w_merge = 1'b0;
`endif

    assign w_alloc = w_push && !w_merge;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[r_head + PW'(i)] && (r_addr[r_head + PW'(i)] == ld_addr)) begin
                w_hit = 1'b1;
                w_fwd = r_data[r_head + PW'(i)];
            end
        end
    end

    assign ld_hit  = w_hit;
    assign ld_data = w_hit ? w_fwd : mem_rdata;

    always_comb begin
        w_sel = PORT_IDLE;
        if (ld_req && !w_hit) begin
            w_sel = PORT_LOAD;
        end else if (r_count != '0) begin
            w_sel = PORT_DRAIN;
        end
    end

    assign mem_read  = (w_sel == PORT_LOAD);
    assign mem_write = w_drain && rst_n;
    assign mem_addr  = w_drain ? r_addr[r_head] : ld_addr;
    assign mem_wdata = r_data[r_head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_alloc) - CW'(w_drain);
        end
    end

    // Payload storage carries no reset; r_valid qualifies every read of it.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end else if (w_merge) begin
            r_data[w_youngest] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a word-addressed data_memory model.
// Expectations follow STORE_BUFFER_COALESCE_EN when the bench is built with it.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [256];
    int          wr20;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .empty(empty), .count(count)
    );

    // Memory model: combinational read; reset refills a known pattern 0x5A5A0000 | word index.
    assign mem_rdata = mem_arr[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h5A5A_0000 | 32'(i);
            wr20 <= 0;
        end else if (mem_write) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
            if (mem_addr == 32'h20) wr20 <= wr20 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_out();
        for (int n = 0; n < 20 && empty !== 1'b1; n++) tick();
        chk("drain_done", 32'(empty), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_req = 1'b0; ld_addr = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_mwrite", 32'(mem_write), 32'd0);
        chk("rst_mread", 32'(mem_read), 32'd0);
        chk("rst_hit", 32'(ld_hit), 32'd0);

        // Basic drain
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hDEADBEEF;
        #1;
        chk("bd_nowrite", 32'(mem_write), 32'd0);
        tick();
        st_valid = 1'b0;
        #1;
        chk("bd_mwrite", 32'(mem_write), 32'd1);
        chk("bd_maddr", mem_addr, 32'h10);
        chk("bd_mwdata", mem_wdata, 32'hDEADBEEF);
        chk("bd_count", 32'(count), 32'd1);
        tick();
        #1;
        chk("bd_empty", 32'(empty), 32'd1);
        chk("bd_mem", mem_arr[4], 32'hDEADBEEF);

        // Full while a load miss stalls the drain
        ld_req = 1'b1; ld_addr = 32'h100;
        for (int k = 0; k < 5; k++) begin
            st_valid = 1'b1; st_addr = 32'(4 * k); st_data = 32'hA0 + 32'(k);
            #1;
            chk("full_mread", 32'(mem_read), 32'd1);
            chk("full_mwrite", 32'(mem_write), 32'd0);
            if (k < 4) begin
                chk("full_ready", 32'(st_ready), 32'd1);
            end else begin
                chk("full_notready", 32'(st_ready), 32'd0);
                chk("full_count", 32'(count), 32'd4);
                chk("full_lddata", ld_data, 32'h5A5A0040);
            end
            tick();
        end
        st_valid = 1'b0; ld_req = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            chk("order_mwrite", 32'(mem_write), 32'd1);
            chk("order_maddr", mem_addr, 32'(4 * j));
            chk("order_mwdata", mem_wdata, 32'hA0 + 32'(j));
            tick();
        end
        chk("order_empty", 32'(empty), 32'd1);

        // Forwarding from the youngest matching entry
        ld_req = 1'b1; ld_addr = 32'h200;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h11111111;
        tick();
        st_data = 32'h22222222;
        tick();
        st_valid = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
        chk("fwd_count", 32'(count), 32'd1);
`else
        chk("fwd_count", 32'(count), 32'd2);
`endif
        ld_addr = 32'h20;
        #1;
        chk("fwd_hit", 32'(ld_hit), 32'd1);
        chk("fwd_data", ld_data, 32'h22222222);
        chk("fwd_mread", 32'(mem_read), 32'd0);
        chk("fwd_drain", 32'(mem_write), 32'd1);
`ifdef STORE_BUFFER_COALESCE_EN
        chk("fwd_headdata", mem_wdata, 32'h22222222);
`else
        chk("fwd_headdata", mem_wdata, 32'h11111111);
`endif
        ld_addr = 32'h24;
        #1;
        chk("miss_hit", 32'(ld_hit), 32'd0);
        chk("miss_mread", 32'(mem_read), 32'd1);
        chk("miss_mwrite", 32'(mem_write), 32'd0);
        chk("miss_maddr", mem_addr, 32'h24);
        chk("miss_data", ld_data, 32'h5A5A0009);
        ld_req = 1'b0;
        drain_out();
        chk("fwd_mem", mem_arr[8], 32'h22222222);
`ifdef STORE_BUFFER_COALESCE_EN
        chk("fwd_nwrites", 32'(wr20), 32'd1);
`else
        chk("fwd_nwrites", 32'(wr20), 32'd2);
`endif

        // Simultaneous push and drain at count=2
        ld_req = 1'b1; ld_addr = 32'h300;
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'hB0;
        tick();
        st_addr = 32'h34; st_data = 32'hB1;
        tick();
        ld_req = 1'b0; st_addr = 32'h38; st_data = 32'hB2;
        #1;
        chk("pd_count_pre", 32'(count), 32'd2);
        chk("pd_mwrite", 32'(mem_write), 32'd1);
        chk("pd_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        chk("pd_count", 32'(count), 32'd2);
        drain_out();
        chk("pd_mem30", mem_arr[12], 32'hB0);
        chk("pd_mem34", mem_arr[13], 32'hB1);
        chk("pd_mem38", mem_arr[14], 32'hB2);

        // Ten back-to-back stores wrap the pointers
        for (int k = 0; k < 10; k++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * k); st_data = 32'hC0 + 32'(k);
            tick();
        end
        st_valid = 1'b0;
        chk("wrap_count", 32'(count), 32'd1);
        drain_out();
        for (int k = 0; k < 10; k++) begin
            chk("wrap_mem", mem_arr[16 + k], 32'hC0 + 32'(k));
        end

        // Reset mid-operation discards pending stores
        ld_req = 1'b1; ld_addr = 32'h3F0;
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1; st_addr = 32'h80 + 32'(4 * k); st_data = 32'hE0 + 32'(k);
            tick();
        end
        st_valid = 1'b0;
        chk("mr_count3", 32'(count), 32'd3);
        rst_n = 1'b0; ld_req = 1'b0;
        #1;
        chk("mr_nowrite_rst", 32'(mem_write), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_nowrite", 32'(mem_write), 32'd0);
        tick(); tick();
        chk("mr_mem80", mem_arr[32], 32'h5A5A0020);
        chk("mr_mem84", mem_arr[33], 32'h5A5A0021);

`ifdef STORE_BUFFER_COALESCE_EN
        // Two stores to one address while stalled merge into a single write
        ld_req = 1'b1; ld_addr = 32'h3F0;
        st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h1;
        tick();
        st_data = 32'h2;
        tick();
        st_valid = 1'b0;
        chk("co_count", 32'(count), 32'd1);
        ld_req = 1'b0;
        #1;
        chk("co_mwdata", mem_wdata, 32'h2);
        drain_out();
        chk("co_mem", mem_arr[16], 32'h2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
